// File: rtl/sram_arbiter_nport.sv
// N-port arbiter time-multiplexing one asynchronous SRAM between several masters.
// Reads take P1-P2, writes take P1-P2-P3; completion is acknowledged one cycle after the final phase.
module sram_arbiter_nport #(
  parameter int NPORTS = 2,
  parameter int AW     = 19,
  parameter int DW     = 8,
  parameter bit PRIO0  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    wr,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] din,
  output logic [NPORTS-1:0]    ack,
  output logic [DW-1:0]        dout,
  output logic [2:0]           grant,
  output logic                 busy,
  output logic [AW-1:0]        sram_addr,
  inout  wire  [DW-1:0]        sram_data,
  output logic                 sram_we_n
);

  localparam logic [2:0] FIRST = PRIO0 ? 3'd1 : 3'd0;
  localparam logic [2:0] LAST  = 3'(NPORTS - 1);

  typedef enum logic [1:0] {IDLE, P1, P2, P3} state_t;

  state_t          state, state_n;
  logic [2:0]      cur;
  logic            cur_wr;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   dout_q;
  logic [2:0]      rr_ptr;
  logic            we_n_q;
  logic            oe_q;
  logic [7:0]      ack_q;

  logic [7:0]      req8, mask8, elig;
  logic            win_valid;
  logic [2:0]      win, rr_next, c;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_din;
  logic            sel_wr;
  logic            load, done, wr_next;

  // In IDLE the port being acknowledged this cycle is masked; at the last
  // phase the port currently being served is masked.
  always_comb begin
    req8 = '0;
    req8[NPORTS-1:0] = req;
    mask8 = (state == IDLE) ? ack_q : (8'd1 << cur);
    elig = req8 & ~mask8;
  end

  always_comb begin
    win_valid = 1'b0;
    win       = FIRST;
    rr_next   = rr_ptr;
    c         = rr_ptr;
    if (PRIO0 && elig[0]) begin
      win_valid = 1'b1;
      win       = 3'd0;
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (!win_valid && (k < NPORTS - int'(FIRST)) && elig[c]) begin
          win_valid = 1'b1;
          win       = c;
        end
        c = (c == LAST) ? FIRST : c + 3'd1;
      end
    end
    if (win_valid && !(PRIO0 && win == 3'd0))
      rr_next = (win == LAST) ? FIRST : win + 3'd1;
  end

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (win == 3'(i)) begin
        sel_addr = addr[i*AW +: AW];
        sel_din  = din[i*DW +: DW];
        sel_wr   = wr[i];
      end
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_n = P1;
          load    = 1'b1;
        end
      end
      P1: state_n = P2;
      P2: begin
        if (cur_wr) begin
          state_n = P3;
        end else begin
          done    = 1'b1;
          state_n = win_valid ? P1 : IDLE;
          load    = win_valid;
        end
      end
      P3: begin
        done    = 1'b1;
        state_n = win_valid ? P1 : IDLE;
        load    = win_valid;
      end
      default: state_n = IDLE;
    endcase
    wr_next = load ? sel_wr : cur_wr;
  end

  // Strobe and bus enable are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur     <= 3'd0;
      cur_wr  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      rr_ptr  <= FIRST;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state  <= state_n;
      we_n_q <= !((state_n == P2) && wr_next);
      oe_q   <= (state_n != IDLE) && wr_next;
      ack_q  <= done ? (8'd1 << cur) : 8'd0;
      if (load) begin
        cur     <= win;
        cur_wr  <= sel_wr;
        addr_q  <= sel_addr;
        wdata_q <= sel_din;
        rr_ptr  <= rr_next;
      end
      if (state == P2 && !cur_wr)
        dout_q <= sram_data;
    end
  end

  assign sram_data = oe_q ? wdata_q : {DW{1'bz}};
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign ack       = ack_q[NPORTS-1:0];
  assign dout      = dout_q;
  assign grant     = cur;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter_nport.sv
// Bench for sram_arbiter_nport (4 ports, port 0 priority) with an SRAM model,
// a memory reference model and a rule-based arbitration model.
module tb_sram_arbiter_nport;
  localparam int N  = 4;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam bit PRIO0 = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req, wr;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   din;
  wire  [N-1:0]      ack;
  wire  [DW-1:0]     dout;
  wire  [2:0]        grant;
  wire               busy;
  wire  [AW-1:0]     sram_addr;
  wire  [DW-1:0]     sram_data;
  wire               sram_we_n;

  logic [DW-1:0]     sram_mem [0:(1<<AW)-1];
  logic [DW-1:0]     ref_mem [int];
  logic [N-1:0]      port_wr;
  logic              probe_en;
  logic [31:0]       exp_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;

  logic              we_s   [0:7];
  logic [AW-1:0]     addr_s [0:7];
  logic [DW-1:0]     data_s [0:7];

  sram_arbiter_nport #(.NPORTS(N), .AW(AW), .DW(DW), .PRIO0(PRIO0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .din(din),
    .ack(ack), .dout(dout), .grant(grant), .busy(busy),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM drives the bus while a read is in progress; the probe drives a known
  // pattern so a released bus can be told apart from a driven one.
  wire sram_oe = busy && (grant < 3'(N)) && !port_wr[grant[1:0]];
  assign sram_data = probe_en ? 8'hA5 : (sram_oe ? sram_mem[sram_addr] : {DW{1'bz}});

  always @(negedge clk)
    if (rst_n && !sram_we_n) sram_mem[sram_addr] <= sram_data;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [AW-1:0] pa;
    pa = sram_addr;
    @(posedge clk);
    #1;
    if (!sram_we_n) check("we_low_addr_stable", 32'(sram_addr), 32'(pa));
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[p*AW +: AW] = a;
    din[p*DW +: DW]  = d;
    wr[p]      = w;
    port_wr[p] = w;
  endtask

  task automatic do_reset();
    req      = '0;
    probe_en = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("reset_we_n", 32'(sram_we_n), 32'd1);
    check("reset_bus_released", 32'(sram_data), 32'hA5);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_addr", 32'(sram_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    probe_en = 1'b0;
    rst_n    = 1'b1;
  endtask

  // Arbitration rule: mask the last winner, port 0 first under priority,
  // otherwise first pending port at or after rr in the round-robin ring.
  task automatic ref_pick(input logic [N-1:0] pend, input int last, input int rr_in,
                          output int win, output int rr_out);
    int first, m, p;
    first  = PRIO0 ? 1 : 0;
    m      = N - first;
    win    = -1;
    rr_out = rr_in;
    if (PRIO0 && pend[0] && last != 0) begin
      win = 0;
    end else begin
      for (int k = 0; k < m; k++) begin
        p = first + ((rr_in - first + k) % m);
        if (win < 0 && pend[p] && p != last) begin
          win    = p;
          rr_out = first + ((p - first + 1) % m);
        end
      end
    end
  endtask

  task automatic single(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output int we_low);
    set_port(p, w, a, d);
    req[p] = 1'b1;
    lat    = 0;
    we_low = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      lat++;
      if (!sram_we_n) we_low++;
      if (lat < 8) begin
        we_s[lat]   = sram_we_n;
        addr_s[lat] = sram_addr;
        data_s[lat] = sram_data;
      end
      if (ack[p]) break;
    end
    req[p] = 1'b0;
  endtask

  task automatic run_stream(input string tag, input logic [N-1:0] ports, input int n, input logic hold0);
    int win, rr, last, got, prev_cyc, cyc;
    logic [N-1:0] rearm;
    logic [DW-1:0] v;
    logic [31:0] e;
    exp_q.delete();
    rr = PRIO0 ? 1 : 0;
    last = -1;
    for (int i = 0; i < n; i++) begin
      ref_pick(ports, last, rr, win, rr);
      exp_q.push_back(32'(win));
      last = win;
    end
    for (int p = 0; p < N; p++) begin
      v = 8'($urandom);
      sram_mem[19'h200 + p] = v;
      ref_mem[32'h200 + p]  = v;
      set_port(p, 1'b0, 19'(32'h200 + p), 8'h00);
    end
    rearm = '0;
    req   = ports;
    got = 0; prev_cyc = 0; cyc = 0;
    while (got < n && cyc < 40) begin
      cycle();
      cyc++;
      if (ack != '0) begin
        e = exp_q.pop_front();
        check({tag, "_order"}, 32'(ack), 32'd1 << e);
        check({tag, "_rd_data"}, 32'(dout), 32'(ref_mem[32'h200 + e]));
        if (got > 0) check({tag, "_spacing"}, 32'(cyc - prev_cyc), 32'd2);
        prev_cyc = cyc;
        got++;
      end
      for (int p = 0; p < N; p++) begin
        if (ports[p] && ack[p] && !(hold0 && p == 0)) begin
          req[p]   = 1'b0;
          rearm[p] = 1'b1;
        end else if (rearm[p]) begin
          req[p]   = 1'b1;
          rearm[p] = 1'b0;
        end
      end
    end
    check({tag, "_count"}, 32'(got), 32'(n));
    req = '0;
    for (int i = 0; i < 10 && busy; i++) cycle();
    cycle();
    check({tag, "_drain"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, wl, busy_cnt, ack2_at, ack3_n, g3_n;
    int n_issued, n_done, n_out;
    logic [DW-1:0] d2, last_rd, v;
    int idle_cnt [N];
    logic outst [N];
    logic t_wr [N];
    logic [AW-1:0] t_addr [N];
    logic [DW-1:0] t_data [N];

    rst_n = 1'b1; req = '0; wr = '0; addr = '0; din = '0; port_wr = '0; probe_en = 1'b0;
    for (int a = 32'h100; a < 32'h120; a++) begin
      v = 8'($urandom);
      sram_mem[a] = v;
      ref_mem[a]  = v;
    end
    #2;
    do_reset();

    // single read
    sram_mem[19'h12345] = 8'h5A;
    single(1, 1'b0, 19'h12345, 8'h00, lat, wl);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_we_never_low", 32'(wl), 32'd0);
    check("rd_dout", 32'(dout), 32'h5A);
    check("rd_ack_onehot", 32'(ack), 32'b0010);
    check("rd_grant", 32'(grant), 32'd1);
    cycle();
    check("rd_ack_pulse_one_cycle", 32'(ack), 32'd0);
    check("rd_idle_after", 32'(busy), 32'd0);

    // single write
    single(1, 1'b1, 19'h00010, 8'hC3, lat, wl);
    check("wr_latency", 32'(lat), 32'd4);
    check("wr_we_low_cycles", 32'(wl), 32'd1);
    check("wr_we_pattern", {29'd0, we_s[1], we_s[2], we_s[3]}, 32'b101);
    for (int i = 1; i <= 3; i++) begin
      check("wr_addr_held", 32'(addr_s[i]), 32'h10);
      check("wr_data_held", 32'(data_s[i]), 32'hC3);
    end
    check("wr_mem_content", 32'(sram_mem[19'h10]), 32'hC3);
    check("wr_keeps_dout", 32'(dout), 32'h5A);
    cycle();

    do_reset();
    run_stream("rr", 4'b1110, 6, 1'b0);
    do_reset();
    run_stream("prio", 4'b0111, 6, 1'b1);

    // reset asserted during P2 of a write
    do_reset();
    set_port(1, 1'b1, 19'h00020, 8'h7E);
    req[1] = 1'b1;
    cycle();
    cycle();
    check("rstw_we_low_in_p2", 32'(sram_we_n), 32'd0);
    req[1]   = 1'b0;
    probe_en = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("rstw_we_high", 32'(sram_we_n), 32'd1);
    check("rstw_bus_released", 32'(sram_data), 32'hA5);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_no_ack", 32'(ack), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rstw_ack_never", 32'(ack), 32'd0);
      check("rstw_stays_idle", 32'(busy), 32'd0);
    end
    probe_en = 1'b0;

    // late drop by port 2, early drop by port 3
    do_reset();
    sram_mem[19'h300] = 8'h66;
    sram_mem[19'h301] = 8'h77;
    set_port(2, 1'b0, 19'h300, 8'h00);
    set_port(3, 1'b0, 19'h301, 8'h00);
    req[2] = 1'b1;
    req[3] = 1'b1;
    busy_cnt = 0; ack2_at = 0; ack3_n = 0; g3_n = 0; d2 = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (busy) busy_cnt++;
      if (busy && grant == 3'd3) g3_n++;
      if (ack[2]) begin ack2_at = i; d2 = dout; end
      if (ack[3]) ack3_n++;
      if (i == 1) req[3] = 1'b0;
      if (i == 2) req[2] = 1'b0;
    end
    check("late_ack2_cycle", 32'(ack2_at), 32'd3);
    check("late_rd_data", 32'(d2), 32'h66);
    check("late_busy_cycles", 32'(busy_cnt), 32'd2);
    check("early_no_ack3", 32'(ack3_n), 32'd0);
    check("early_no_grant3", 32'(g3_n), 32'd0);

    // randomized traffic against the memory reference model
    do_reset();
    last_rd = 8'h00;
    n_issued = 0; n_done = 0;
    for (int p = 0; p < N; p++) begin
      idle_cnt[p] = $urandom_range(0, 3);
      outst[p] = 1'b0;
      t_wr[p] = 1'b0;
      t_addr[p] = '0;
      t_data[p] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      cycle();
      if (ack != '0) check("rand_ack_onehot", 32'($countones(ack)), 32'd1);
      for (int p = 0; p < N; p++) begin
        if (ack[p]) begin
          check("rand_ack_expected", 32'(outst[p]), 32'd1);
          if (t_wr[p]) begin
            ref_mem[32'(t_addr[p])] = t_data[p];
            check("rand_wr_keeps_dout", 32'(dout), 32'(last_rd));
          end else begin
            check("rand_rd_data", 32'(dout), 32'(ref_mem[32'(t_addr[p])]));
            last_rd = ref_mem[32'(t_addr[p])];
          end
          outst[p]    = 1'b0;
          req[p]      = 1'b0;
          idle_cnt[p] = $urandom_range(1, 4);
          n_done++;
        end else if (!outst[p] && cyc < 300) begin
          if (idle_cnt[p] > 0) begin
            idle_cnt[p]--;
          end else begin
            t_wr[p]   = 1'($urandom_range(0, 1));
            t_addr[p] = 19'(32'h100 + $urandom_range(0, 31));
            t_data[p] = 8'($urandom);
            set_port(p, t_wr[p], t_addr[p], t_data[p]);
            req[p]   = 1'b1;
            outst[p] = 1'b1;
            n_issued++;
          end
        end
      end
      n_out = 0;
      for (int p = 0; p < N; p++) if (outst[p]) n_out++;
      if (cyc >= 300 && n_out == 0) break;
    end
    n_out = 0;
    for (int p = 0; p < N; p++) if (outst[p]) n_out++;
    check("rand_all_completed", 32'(n_out), 32'd0);
    check("rand_issued_vs_done", 32'(n_done), 32'(n_issued));
    for (int a = 32'h100; a < 32'h120; a++)
      check("rand_mem_image", 32'(sram_mem[a]), 32'(ref_mem[a]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter_nport.md
# sram_arbiter_nport

Parametrised N-port arbiter giving several masters time-multiplexed access to one asynchronous external SRAM over a shared address, data and write-enable bus. It generalises the fixed two-way video/CPU turn scheme to NPORTS requesters. It uses a req/ack handshake, optional hard priority for port 0 (video fetch) and round-robin among the rest. It sits between the ASIC/CPU/DMA masters and the top-level SRAM pins.

## Interface
- NPORTS, 2: number of requesters, 2..8.
- AW, 19: address width.
- DW, 8: data width.
- PRIO0, 1: 1 = port 0 always wins arbitration; 0 = port 0 joins the round-robin.

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NPORTS  per-port request level, held until ack.
- wr  in  NPORTS  per-port access type, 1 = write, 0 = read; sampled at grant.
- addr  in  NPORTS*AW  flattened addresses; port i occupies [i*AW +: AW].
- din  in  NPORTS*DW  flattened write data, same packing.
- ack  out  NPORTS  one-cycle completion pulse for the served port.
- dout  out  DW  last read data; shared by all ports; valid with ack.
- grant  out  3  index of the port being served, or last served port when idle.
- busy  out  1  high in any state other than IDLE.
- sram_addr  out  AW  SRAM address.
- sram_data  inout  DW  SRAM data bus.
- sram_we_n  out  1  SRAM write strobe, active low.

## Operation
- States: IDLE, P1, P2, P3. P3 is used for writes only.
- Arbitration runs in IDLE and at the last phase of an access (P2 for reads, P3 for writes):
  - The port just served is masked from that decision.
  - If PRIO0=1 and req[0] is high, port 0 wins.
  - Otherwise the winner is the first requesting port at or after rr_ptr, wrapping at NPORTS-1 back to the first round-robin port (1 if PRIO0=1, else 0).
  - rr_ptr becomes winner+1, with the same wrap rule. A port-0 win under PRIO0=1 leaves rr_ptr unchanged.
- On grant, latch addr/din/wr of the winner into internal registers. Later changes on that port's inputs are ignored until ack.
- P1: sram_addr is driven. For a write, sram_data is also driven; sram_we_n stays 1.
- P2:
  - Read: sram_data is hi-Z; sram_data is registered into dout at the end of P2.
  - Write: sram_we_n=0 and data is driven.
- P3 (write only): sram_we_n=1; address and data are held for hold time. Data is released at the end of P3.
- ack[winner] pulses in the cycle after the final phase. That cycle is P1 of the next access when another request is pending, so back-to-back accesses have no idle gap.
- A requester must drop req in its ack cycle. If req is still high after that cycle, it is treated as a new request.
- Writes do not modify dout.
- sram_data is hi-Z in IDLE and during all read phases.

## Timing
- Reset values (asynchronous): state=IDLE, sram_we_n=1, sram_data=hi-Z, sram_addr=0, ack=0, dout=0, grant=0, busy=0, rr_ptr = first round-robin port.
- Read latency: req sampled high at edge E0 → P1 after E0, P2 after E1 → dout and ack valid after E2, i.e. 3 cycles.
- Write latency: ack after E3, i.e. 4 cycles.
- Throughput: one read every 2 cycles, one write every 3 cycles.
- sram_we_n is never low in the same cycle that sram_addr changes.
- Simultaneous requests from all ports are resolved by the rules above. With PRIO0=1, port 0 is granted at most once per access boundary and cannot starve the others: the mask prevents two consecutive grants to port 0.
- req dropped before grant: no access, no ack. req dropped after grant: the access completes and ack still pulses.
- Reset asserted mid-access: immediate return to IDLE, sram_we_n=1, bus released, no ack.
- grant index is zero-extended to 3 bits.

## Test plan
- Single read, NPORTS=2: SRAM model holds 0x5A at 0x12345; port 1 reads 0x12345 → sram_we_n stays 1, dout=0x5A with ack[1] exactly 3 cycles after req is sampled.
- Single write: port 1 writes 0xC3 to 0x00010 → sram_we_n low for exactly 1 cycle, address and data stable one cycle before and after it, ack[1] after 4 cycles, model holds 0xC3.
- Round-robin, NPORTS=4, PRIO0=1: ports 1, 2, 3 all request repeated reads, each re-requesting after its ack → grant order 1, 2, 3, 1, 2, 3 with reads 2 cycles apart.
- Priority with starvation guard: port 0 requests continuously alongside ports 1 and 2 → grants alternate 0, 1, 0, 2, 0, 1.
- Reset mid-write: assert rst_n=0 during P2 of a write → sram_we_n=1 and sram_data hi-Z within the same cycle, ack never pulses, busy=0.
- Late-drop handling: port 2 drops req one cycle after it was sampled → its access still completes and ack[2] pulses. A second port that drops req before being granted gets no ack and no SRAM cycle.
